id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS pipeline, directly downstream of the register file and decoder.
- Captures the decoded instruction fields, both register-file operands, the immediate and control bits on each rising clock edge, and presents them to EX.
- Owns load-use hazard detection: on a hazard it requests an upstream stall and inserts one bubble into EX.
- Also honours a downstream hold and a branch/jump flush.

---
 rtl/id_ex_stage.sv | 205 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS pipeline.
// Captures decoded fields, operands, immediate and control bits for EX.
// Detects load-use hazards against the load currently in EX. On a hazard it
// stalls the front end and injects a single bubble.
// Optional feature macro: ID_EX_STAT_EN adds a saturating 16-bit bubble_count
// output that counts load-use bubbles.
//
// Flow control: an instruction moves from ID into EX on a rising edge. This
// happens only when flush, ex_hold and load_use are all low; id_valid marks
// the payload as real. stall_up is the not-ready signal seen by PC and IF/ID:
// while it is high they must hold their contents.
// ex_hold is the not-ready signal from EX: while it is high this stage freezes.
// flush overrides both and always loads a bubble.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
`ifdef ID_EX_STAT_EN
  output logic [15:0]       bubble_count,
`endif
  output logic              stall_up
);

  // Pipeline register contents
  logic              valid_q,     valid_d;
  logic [REG_AW-1:0] rs_q,        rs_d;
  logic [REG_AW-1:0] rt_q,        rt_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic [DATA_W-1:0] rs_data_q,   rs_data_d;
  logic [DATA_W-1:0] rt_data_q,   rt_data_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic              mem_read_q,  mem_read_d;
  logic              reg_write_q, reg_write_d;

  // Decoded per-edge action
  logic load_use;
  logic rd_nonzero;
  logic rs_match;
  logic rt_match;
  logic do_bubble;
  logic do_hold;
  logic do_load;

  // Hazard detection: a load in EX whose destination is read by the
  // instruction in ID. A load into $0 never produces a real value, so it
  // never creates a hazard.
  always_comb begin
    rd_nonzero = (rd_q != '0);
    rs_match   = (rd_q == id_rs);
    rt_match   = id_uses_rt && (rd_q == id_rt);
    load_use   = id_valid && valid_q && mem_read_q && rd_nonzero &&
                 (rs_match || rt_match);
  end

  assign stall_up = load_use || ex_hold;

  // Edge action priority: flush, then hold, then load-use bubble, then load
  always_comb begin
    do_bubble = 1'b0;
    do_hold   = 1'b0;
    do_load   = 1'b0;
    if (flush) begin
      do_bubble = 1'b1;
    end else if (ex_hold) begin
      do_hold = 1'b1;
    end else if (load_use) begin
      do_bubble = 1'b1;
    end else begin
      do_load = 1'b1;
    end
  end

  // Next-state selection for the pipeline register
  always_comb begin
    valid_d     = valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    if (do_bubble) begin
      valid_d     = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      ctrl_d      = '0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else if (do_load) begin
      valid_d     = id_valid;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      ctrl_d      = id_ctrl;
      // An empty ID slot must never write a register or touch memory.
      mem_read_d  = id_valid && id_mem_read;
      reg_write_d = id_valid && id_reg_write;
    end else if (do_hold) begin
      valid_d = valid_q;
    end
  end

  // Pipeline register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign ex_rs_data   = rs_data_q;
  assign ex_rt_data   = rt_data_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;

`ifdef ID_EX_STAT_EN
  logic [15:0] bub_cnt_q, bub_cnt_d;
  logic        lu_bubble;

  // Only bubbles caused by load-use count; flush bubbles and holds do not
  assign lu_bubble = !flush && !ex_hold && load_use;

  // Saturating increment of the load-use bubble count
  always_comb begin
    bub_cnt_d = bub_cnt_q;
    if (lu_bubble && (bub_cnt_q != 16'hFFFF)) begin
      bub_cnt_d = bub_cnt_q + 16'd1;
    end
  end

  // Bubble counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bub_cnt_q <= 16'd0;
    end else begin
      bub_cnt_q <= bub_cnt_d;
    end
  end

  assign bubble_count = bub_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed bench for id_ex_stage with a
// record-level reference model of the EX-side contents.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;
  localparam int BW = 1 + 3*REG_AW + 3*DATA_W + CTRL_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              id_valid, id_uses_rt, id_mem_read, id_reg_write;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, ex_hold;
  logic              ex_valid, ex_mem_read, ex_reg_write, stall_up;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
`ifdef ID_EX_STAT_EN
  logic [15:0]       bubble_count;
`endif

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
`ifdef ID_EX_STAT_EN
    .bubble_count(bubble_count),
`endif
    .stall_up(stall_up)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rsd, rtd, imm;
    logic [CTRL_W-1:0] ctrl;
    logic              mr, rw;
  } ex_t;

  ex_t          m;
  int unsigned  m_bub;
  logic [BW-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic ex_t dut_word();
    ex_t w;
    w.v = ex_valid; w.rs = ex_rs; w.rt = ex_rt; w.rd = ex_rd;
    w.rsd = ex_rs_data; w.rtd = ex_rt_data; w.imm = ex_imm;
    w.ctrl = ex_ctrl; w.mr = ex_mem_read; w.rw = ex_reg_write;
    return w;
  endfunction

  // A load sitting in EX blocks an ID instruction that reads its target
  function automatic bit m_hazard();
    bit reads;
    reads = (m.rd == id_rs) || (id_uses_rt && (m.rd == id_rt));
    return id_valid && m.v && m.mr && (m.rd != 0) && reads;
  endfunction

  task automatic model_reset();
    m = '0;
    m_bub = 0;
    exp_q.delete();
  endtask

  // Apply one clock edge to the model using the current ID/control inputs
  task automatic model_edge();
    bit hz;
    ex_t nx;
    hz = m_hazard();
    nx = m;
    if (flush || (!ex_hold && hz)) begin
      nx = '0;
      if (!flush && hz && m_bub < 65535) m_bub++;
    end else if (!ex_hold) begin
      nx.v = id_valid; nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
      nx.rsd = id_rs_data; nx.rtd = id_rt_data; nx.imm = id_imm;
      nx.ctrl = id_ctrl;
      nx.mr = id_valid ? id_mem_read : 1'b0;
      nx.rw = id_valid ? id_reg_write : 1'b0;
    end
    m = nx;
    exp_q.push_back(nx);
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input int rs, input int rt, input int rd,
                        input logic urt, input logic [DATA_W-1:0] rsd,
                        input logic [DATA_W-1:0] rtd, input logic mr,
                        input logic rw);
    id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt); id_rd = REG_AW'(rd);
    id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
    id_mem_read = mr; id_reg_write = rw;
  endtask

  // Entered just after a falling edge with inputs applied; leaves at the
  // next falling edge after checking the registered outputs.
  task automatic tick();
    ex_t e;
    #1;
    check_eq("stall_up", 128'(stall_up), 128'(m_hazard() || ex_hold));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("ex_bundle", 128'(dut_word()), 128'(e));
`ifdef ID_EX_STAT_EN
    check_eq("bubble_count", 128'(bubble_count), 128'(m_bub));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_bundle", 128'(dut_word()), 128'(0));
    check_eq("reset_stall", 128'(stall_up), 128'(0));
`ifdef ID_EX_STAT_EN
    check_eq("reset_count", 128'(bubble_count), 128'(0));
`endif
    rst = 1'b0;

    // Plain load after reset
    set_id(1, 2, 3, 4, 1, 32'h11, 32'h22, 0, 1);
    tick();
    check_eq("plain_rd", 128'(ex_rd), 128'(4));
    check_eq("plain_rs_data", 128'(ex_rs_data), 128'(32'h11));
    check_eq("plain_rt_data", 128'(ex_rt_data), 128'(32'h22));
    check_eq("plain_valid", 128'(ex_valid), 128'(1));

    // Load-use on rs: one bubble, then the held instruction loads
    set_id(1, 1, 2, 5, 1, 32'h5, 32'h6, 1, 1);
    tick();
    set_id(1, 5, 6, 8, 0, 32'h55, 32'h66, 0, 1);
    #1 check_eq("lu_rs_stall", 128'(stall_up), 128'(1));
    tick();
    check_eq("lu_bubble_valid", 128'(ex_valid), 128'(0));
    check_eq("lu_bubble_rw", 128'(ex_reg_write), 128'(0));
    tick();
    check_eq("lu_held_valid", 128'(ex_valid), 128'(1));
    check_eq("lu_held_rs", 128'(ex_rs), 128'(5));

    // rt only matters when the instruction reads rt
    set_id(1, 1, 2, 7, 1, 1, 2, 1, 1);
    tick();
    set_id(1, 1, 7, 9, 0, 3, 4, 0, 1);
    #1 check_eq("rt_unused_stall", 128'(stall_up), 128'(0));
    tick();
    set_id(1, 1, 2, 7, 1, 1, 2, 1, 1);
    tick();
    set_id(1, 1, 7, 9, 1, 3, 4, 0, 1);
    #1 check_eq("rt_used_stall", 128'(stall_up), 128'(1));
    tick();
    tick();
    // Load into $0 never stalls
    set_id(1, 1, 2, 0, 1, 1, 2, 1, 1);
    tick();
    set_id(1, 0, 0, 3, 1, 3, 4, 0, 1);
    #1 check_eq("r0_stall", 128'(stall_up), 128'(0));
    tick();

    // ex_hold freezes EX for three cycles
    set_id(1, 10, 11, 12, 1, 32'hA0, 32'hA1, 0, 1);
    tick();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 20 + i, 21, 22, 1, $urandom, $urandom, 0, 1);
      tick();
    end
    check_eq("hold_rd", 128'(ex_rd), 128'(12));
    check_eq("hold_rs_data", 128'(ex_rs_data), 128'(32'hA0));
    ex_hold = 1'b0;
    tick();
    check_eq("hold_release_rs", 128'(ex_rs), 128'(22));

    // flush beats hold and load-use
    set_id(1, 1, 2, 9, 1, 1, 2, 1, 1);
    tick();
    set_id(1, 9, 2, 3, 1, 5, 6, 0, 1);
    flush = 1'b1; ex_hold = 1'b1;
    #1 check_eq("flush_stall", 128'(stall_up), 128'(1));
    tick();
    check_eq("flush_valid", 128'(ex_valid), 128'(0));
    check_eq("flush_ctrl", 128'(ex_ctrl), 128'(0));
    flush = 1'b0; ex_hold = 1'b0;

    // Async reset in the middle of a load-use stall
    set_id(1, 1, 2, 6, 1, 1, 2, 1, 1);
    tick();
    set_id(1, 6, 2, 3, 1, 5, 6, 0, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_bundle", 128'(dut_word()), 128'(0));
    check_eq("arst_stall", 128'(stall_up), 128'(0));
`ifdef ID_EX_STAT_EN
    check_eq("arst_count", 128'(bubble_count), 128'(0));
`endif
    rst = 1'b0;
    model_reset();
    tick();
    // Three load-use bubbles
    for (int i = 0; i < 3; i++) begin
      set_id(1, 1, 2, 13, 1, 1, 2, 1, 1);
      tick();
      set_id(1, 13, 2, 3, 0, 5, 6, 0, 1);
      tick();
      tick();
    end
`ifdef ID_EX_STAT_EN
    check_eq("count_three", 128'(bubble_count), 128'(3));
`endif

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 7) != 0), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      flush   = ($urandom_range(0, 15) == 0);
      ex_hold = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
